// File: rtl/fetch_icache_dm.sv
// Direct-mapped instruction cache with one-request lookahead and single-beat-wide
// line refill; hits respond one cycle after acceptance.
module fetch_icache_dm #(
    parameter int ADDR_W     = 64,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_pc,
    output logic              resp_valid,
    output logic [31:0]       resp_inst,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] MISS_REQ = 2'd1;
    localparam logic [1:0] REFILL   = 2'd2;
    localparam logic [1:0] RESPOND  = 2'd3;

    logic [1:0]          state_q;
    logic                pending_q;
    logic                flush_latch_q;
    logic [ADDR_W-1:2]   pc_q;
    logic [OFF_W-1:0]    beat_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [31:0]         hit_count_q;
    logic [31:0]         miss_count_q;

    logic [TAG_W-1:0]    tag_mem  [NUM_LINES];
    logic [31:0]         data_mem [NUM_LINES][LINE_WORDS];

    logic [OFF_W-1:0]    req_word;
    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic                lookup_hit;
    logic                hit_fire;
    logic                miss_fire;
    logic                req_fire;
    logic                last_beat;
    logic                beat_fire;
    logic                unused_pc_bits;

    assign unused_pc_bits = ^req_pc[1:0];

    assign req_word = pc_q[2 +: OFF_W];
    assign req_idx  = pc_q[2 + OFF_W +: IDX_W];
    assign req_tag  = pc_q[ADDR_W-1 -: TAG_W];

    assign lookup_hit = pending_q && valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    // A flush in IDLE drops the pending lookup, so neither a hit nor a miss is reported.
    assign hit_fire   = (state_q == IDLE) && !flush && lookup_hit;
    assign miss_fire  = (state_q == IDLE) && !flush && pending_q && !lookup_hit;

    // The reset gate keeps req_ready low while reset is held even though the
    // registered state already reads IDLE.
    assign req_ready  = !reset && (state_q == IDLE) && !flush && (!pending_q || lookup_hit);
    assign req_fire   = req_valid && req_ready;

    assign last_beat  = &beat_q;
    assign beat_fire  = (state_q == REFILL) && mem_resp_valid;

    always_comb begin
        resp_valid = 1'b0;
        resp_inst  = '0;
        if (hit_fire || (state_q == RESPOND)) begin
            resp_valid = 1'b1;
            resp_inst  = data_mem[req_idx][req_word];
        end
    end

    assign mem_req_valid = (state_q == MISS_REQ);
    assign mem_req_addr  = mem_req_valid ? {pc_q[ADDR_W-1:2+OFF_W], {(2+OFF_W){1'b0}}} : '0;
    assign hit_count     = hit_count_q;
    assign miss_count    = miss_count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pending_q     <= 1'b0;
            flush_latch_q <= 1'b0;
            pc_q          <= '0;
            beat_q        <= '0;
            valid_q       <= '0;
            hit_count_q   <= '0;
            miss_count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        valid_q   <= '0;
                        pending_q <= 1'b0;
                    end else begin
                        if (hit_fire) begin
                            hit_count_q <= hit_count_q + 32'd1;
                        end
                        if (miss_fire) begin
                            miss_count_q <= miss_count_q + 32'd1;
                            state_q      <= MISS_REQ;
                        end
                        if (req_fire) begin
                            pc_q      <= req_pc[ADDR_W-1:2];
                            pending_q <= 1'b1;
                        end else begin
                            pending_q <= 1'b0;
                        end
                    end
                end
                MISS_REQ: begin
                    if (flush) begin
                        flush_latch_q <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        beat_q  <= '0;
                        state_q <= REFILL;
                    end
                end
                REFILL: begin
                    if (flush) begin
                        flush_latch_q <= 1'b1;
                    end
                    if (mem_resp_valid) begin
                        beat_q <= beat_q + 1'b1;
                        if (last_beat) begin
                            valid_q[req_idx] <= !(flush_latch_q || flush);
                            state_q          <= RESPOND;
                        end
                    end
                end
                default: begin
                    // RESPOND: a flush seen anywhere during the miss is applied now.
                    state_q   <= IDLE;
                    pending_q <= 1'b0;
                    if (flush_latch_q || flush) begin
                        valid_q       <= '0;
                        flush_latch_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone decide
    // whether their contents are meaningful.
    always_ff @(posedge clk) begin
        if (!reset && beat_fire) begin
            data_mem[req_idx][beat_q] <= mem_resp_data;
            if (last_beat) begin
                tag_mem[req_idx] <= req_tag;
            end
        end
    end

endmodule

// File: tb/tb_fetch_icache_dm.sv
// Scoreboard bench for fetch_icache_dm: expected instructions are queued on
// request acceptance and matched against each resp_valid pulse.
module tb_fetch_icache_dm;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_inst;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int checks   = 0;
    int failures = 0;
    int mem_req_seen = 0;
    logic [31:0] exp_q[$];

    fetch_icache_dm dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_pc         (req_pc),
        .resp_valid     (resp_valid),
        .resp_inst      (resp_inst),
        .flush          (flush),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Response monitor: every pulse must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req_valid) mem_req_seen++;
            if (resp_valid === 1'b1) begin
                if (exp_q.size() == 0) check("unexpected_resp", 64'(resp_inst), 64'hDEAD);
                else check("resp_inst", 64'(resp_inst), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present a request until accepted; optionally queue its expected instruction.
    task automatic issue(input logic [63:0] pc, input logic [31:0] exp, input bit push);
        int n = 0;
        req_valid = 1'b1;
        req_pc    = pc;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_accept", 64'(req_ready), 64'd1);
        @(posedge clk);
        if (push) exp_q.push_back(exp);
        #1;
        req_valid = 1'b0;
    endtask

    // Serve one line refill: optional request stall and optional flush during beat 1.
    task automatic serve_refill(input logic [63:0] addr, input logic [31:0] base,
                                input int stall, input bit flush_mid);
        int n = 0;
        @(negedge clk);
        while (!mem_req_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mem_req_valid", 64'(mem_req_valid), 64'd1);
        for (int i = 0; i < stall; i++) begin
            check("stall_valid", 64'(mem_req_valid), 64'd1);
            check("stall_addr", mem_req_addr, addr);
            check("stall_req_ready", 64'(req_ready), 64'd0);
            @(posedge clk);
            @(negedge clk);
        end
        check("mem_req_addr", mem_req_addr, addr);
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = base + 32'(i);
            flush          = flush_mid && (i == 1);
            @(posedge clk);
            #1;
        end
        flush          = 1'b0;
        mem_resp_valid = 1'b0;
        @(negedge clk);
        check("resp_after_last_beat", 64'(resp_valid), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},     64'(req_ready),     64'd0);
        check({tag, "_resp_valid"},    64'(resp_valid),    64'd0);
        check({tag, "_resp_inst"},     64'(resp_inst),     64'd0);
        check({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'd0);
        check({tag, "_mem_req_addr"},  mem_req_addr,       64'd0);
        check({tag, "_hit_count"},     64'(hit_count),     64'd0);
        check({tag, "_miss_count"},    64'(miss_count),    64'd0);
    endtask

    initial begin
        int seen_before;
        reset          = 1'b1;
        req_valid      = 1'b0;
        req_pc         = '0;
        flush          = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Cold miss
        issue(64'h1000, 32'hA0, 1'b1);
        serve_refill(64'h1000, 32'hA0, 0, 1'b0);
        check("cold_miss_count", 64'(miss_count), 64'd1);

        // Back-to-back hits
        @(posedge clk);
        #1;
        seen_before = mem_req_seen;
        issue(64'h1008, 32'hA2, 1'b1);
        issue(64'h100C, 32'hA3, 1'b1);
        @(negedge clk);
        check("hit_resp_valid", 64'(resp_valid), 64'd1);
        @(negedge clk);
        check("hit_count", 64'(hit_count), 64'd2);
        check("hit_no_mem_req", 64'(mem_req_seen - seen_before), 64'd0);
        check("hit_miss_count", 64'(miss_count), 64'd1);

        // Conflict on index 0
        @(posedge clk);
        #1;
        issue(64'h2004, 32'hB1, 1'b1);
        serve_refill(64'h2000, 32'hB0, 0, 1'b0);
        @(posedge clk);
        #1;
        issue(64'h1000, 32'hC0, 1'b1);
        serve_refill(64'h1000, 32'hC0, 0, 1'b0);
        check("conflict_miss_count", 64'(miss_count), 64'd3);

        // Stalled memory request
        @(posedge clk);
        #1;
        issue(64'h4018, 32'hD2, 1'b1);
        serve_refill(64'h4010, 32'hD0, 5, 1'b0);

        // Flush in IDLE wins over a simultaneous request
        @(posedge clk);
        #1;
        flush     = 1'b1;
        req_valid = 1'b1;
        req_pc    = 64'h1000;
        @(negedge clk);
        check("flush_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        check("flush_no_count", 64'(miss_count), 64'd4);
        issue(64'h1000, 32'hE0, 1'b1);
        serve_refill(64'h1000, 32'hE0, 0, 1'b0);
        check("flush_idle_miss", 64'(miss_count), 64'd5);

        // Flush during refill: response delivered, line left invalid
        @(posedge clk);
        #1;
        issue(64'h5008, 32'hF2, 1'b1);
        serve_refill(64'h5000, 32'hF0, 0, 1'b1);
        @(posedge clk);
        #1;
        issue(64'h5008, 32'h72, 1'b1);
        serve_refill(64'h5000, 32'h70, 0, 1'b0);
        check("flush_refill_miss", 64'(miss_count), 64'd7);
        check("flush_refill_hits", 64'(hit_count), 64'd2);

        // Reset in the middle of a refill
        @(posedge clk);
        #1;
        issue(64'h1000, 32'h0, 1'b0);
        begin
            int n = 0;
            @(negedge clk);
            while (!mem_req_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("rst_mem_req_valid", 64'(mem_req_valid), 64'd1);
        end
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'h55 + 32'(i);
            @(posedge clk);
            #1;
        end
        mem_resp_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'h57 + 32'(i);
            @(negedge clk);
            check("stray_resp_valid", 64'(resp_valid), 64'd0);
            check("stray_mem_req", 64'(mem_req_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        mem_resp_valid = 1'b0;
        check("post_rst_misses", 64'(miss_count), 64'd0);
        issue(64'h1000, 32'h90, 1'b1);
        serve_refill(64'h1000, 32'h90, 0, 1'b0);
        check("post_rst_miss_count", 64'(miss_count), 64'd1);
        check("post_rst_hit_count", 64'(hit_count), 64'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_icache_dm.md
FETCH_ICACHE_DM -- requirements
Module: fetch_icache_dm

Interface
REQ-001 SHALL have parameters, one per line:
  ADDR_W, 64, fetch address width
  LINE_WORDS, 4, 32-bit words per line, power of two >= 2
  NUM_LINES, 256, lines in the cache, power of two >= 2
REQ-002 SHALL have ports, one per line:
  clk  in  1  single clock, all state updates on rising edge
  reset  in  1  synchronous, active-high reset
  req_valid  in  1  fetch request present
  req_ready  out  1  cache can accept a request
  req_pc  in  ADDR_W  fetch address; bits[1:0] ignored
  resp_valid  out  1  one-cycle pulse, resp_inst valid
  resp_inst  out  32  fetched instruction
  flush  in  1  invalidate all lines
  mem_req_valid  out  1  line refill request
  mem_req_ready  in  1  memory accepts request
  mem_req_addr  out  ADDR_W  line-aligned refill address
  mem_resp_valid  in  1  refill beat present
  mem_resp_data  in  32  refill beat, one word
  hit_count  out  32  accepted requests that hit
  miss_count  out  32  accepted requests that missed

Function
REQ-003 SHALL split the address as: OFF = log2(LINE_WORDS); IDX = log2(NUM_LINES); word = pc[2+OFF-1:2]; index = pc[2+OFF+IDX-1:2+OFF]; tag = pc[ADDR_W-1:2+OFF+IDX].
REQ-004 SHALL hold per line: a valid bit, a tag, and LINE_WORDS data words (direct-mapped, asynchronous array read).
REQ-005 SHALL implement FSM states IDLE, MISS_REQ, REFILL and RESPOND.
REQ-006 SHALL accept a request when req_valid && req_ready and register req_pc; a pending lookup exists in the following cycle.
REQ-007 SHALL assert req_ready in IDLE when flush is low and either no lookup is pending or the pending lookup hits; otherwise req_ready = 0.
REQ-008 On a pending lookup that hits (valid && tag match): resp_valid = 1 and resp_inst = the stored word in that cycle, 1-cycle latency, back-to-back hits at one per cycle, hit_count += 1.
REQ-009 On a pending lookup that misses: no response, miss_count += 1, next state MISS_REQ.
REQ-010 MISS_REQ: SHALL assert mem_req_valid with mem_req_addr = registered pc with bits [2+OFF-1:0] zeroed, held stable until mem_req_ready; next state REFILL.
REQ-011 REFILL: each mem_resp_valid beat SHALL write word 0, 1, ..., LINE_WORDS-1 in order; mem_resp_valid outside REFILL SHALL be ignored.
REQ-012 After the last beat: SHALL write the tag, set valid (unless REQ-015 applies), next state RESPOND.
REQ-013 RESPOND: SHALL pulse resp_valid for one cycle with the requested word of the refilled line, then return to IDLE with no lookup pending.
REQ-014 A flush in IDLE SHALL clear all valid bits in one cycle, drop any pending lookup without response or count, and take priority over a simultaneous request (req_ready = 0 that cycle).
REQ-015 A flush in MISS_REQ, REFILL or RESPOND SHALL be latched. The refill completes and responds, but the line is not marked valid, and all valid bits are cleared on entry to IDLE.
REQ-016 Counters SHALL wrap modulo 2^32.

Reset
REQ-017 While reset is high: state = IDLE, all valid bits = 0, no lookup pending, flush latch = 0, resp_valid = 0, resp_inst = 0, mem_req_valid = 0, mem_req_addr = 0, counters = 0, req_ready = 0.
REQ-018 Reset asserted mid-refill SHALL abandon the refill: the partial line stays invalid, and later beats are ignored.
REQ-019 Data and tag arrays need not be reset.

Verification (defaults: OFF = 2, IDX = 8)
REQ-020 Cold miss:
  - Stimulus: req_pc = 0x1000, mem_req_ready = 1, beats 0xA0, 0xA1, 0xA2, 0xA3.
  - Response: mem_req_addr = 0x1000, resp_valid one cycle after the last beat, resp_inst = 0xA0, miss_count = 1.
REQ-021 Hit stream:
  - Stimulus: after REQ-020, back-to-back requests 0x1008 then 0x100C.
  - Response: resp_inst = 0xA2 then 0xA3 on consecutive cycles, each one cycle after acceptance, hit_count = 2, no mem_req_valid.
REQ-022 Conflict:
  - Stimulus: req_pc = 0x2004 (same index, tag 2), beats 0xB0 to 0xB3, then req_pc = 0x1000.
  - Response: 0x2004 returns resp_inst = 0xB1; 0x1000 misses again with mem_req_addr = 0x1000.
REQ-023 Flush:
  - Stimulus: flush in IDLE together with req_valid; then req_pc = 0x1000. Separately, flush asserted during REFILL.
  - Response: req_ready = 0 in the flush cycle; 0x1000 then misses. For the REFILL case, the response is still delivered, and a repeat request to the same address misses.
REQ-024 Reset mid-refill:
  - Stimulus: reset after 2 of 4 beats, then 2 stray beats, then req_pc = 0x1000.
  - Response: stray beats ignored, outputs at reset values, request misses, counters restart at 0.
REQ-025 Stalled memory:
  - Stimulus: mem_req_ready = 0 for 5 cycles.
  - Response: mem_req_valid and mem_req_addr stable throughout, req_ready = 0.
